// File: rtl/root_pkg.sv
// Shared types and width helpers for the batch runner.
package root_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    // Address width of a DEPTH-entry table; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold any count from 0 to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/root_vec_ram.sv
// Register-file table: one synchronous write port, one asynchronous read port.
module root_vec_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/root_batch_runner.sv
// Runs up to DEPTH stored argument vectors through an external function, storing each result.
// Latency per vector: LAUNCH + WAIT (until F_RD) + STORE; RD pulses one cycle after the last STORE.
// Backpressure: waits on F_RD indefinitely, or TIMEOUT cycles when ROOT_BATCH_TIMEOUT_EN is defined.
module root_batch_runner
    import root_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NARGS   = 5,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100000,
    localparam int AW     = addr_w(DEPTH),
    localparam int CW     = cnt_w(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ST,
    input  logic [CW-1:0]          CNT,
    input  logic                   LD_WE,
    input  logic [AW-1:0]          LD_ADDR,
    input  logic [NARGS*WIDTH-1:0] LD_DATA,
    output logic                   F_ST,
    output logic [NARGS*WIDTH-1:0] F_IN,
    input  logic                   F_RD,
    input  logic [WIDTH-1:0]       F_RES,
    input  logic [AW-1:0]          RES_ADDR,
    output logic [WIDTH-1:0]       RES,
    output logic                   RD,
    output logic                   BUSY,
    output logic                   TOUT
);

`ifdef ROOT_BATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TW = cnt_w(TIMEOUT);

    state_t                   state;
    state_t                   state_nxt;
    logic [AW-1:0]            idx;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_clamp;
    logic                     last;
    logic                     accept;
    logic [NARGS*WIDTH-1:0]   vec_rd;
    logic                     vec_we;
    logic                     res_we;
    logic [WIDTH-1:0]         res_wdata;
    logic [TW-1:0]            tcnt;
    logic                     tout_q;
    logic                     to_hit;
    logic                     expire;

    assign cnt_clamp = (CNT > CW'(DEPTH)) ? CW'(DEPTH) : CNT;
    assign last      = (CW'(idx) == cnt_q - CW'(1));
    assign accept    = (state == S_IDLE) && ST;
    assign expire    = TO_EN && (state == S_WAIT) && !F_RD && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt_q <= cnt_clamp;
                idx   <= '0;
            end else if ((state == S_STORE) && !last) begin
                idx <= idx + AW'(1);
            end
        end
    end

    // Timeout machinery is always described; TO_EN keeps it inert in the default build.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt   <= '0;
            tout_q <= 1'b0;
            to_hit <= 1'b0;
        end else begin
            tcnt <= (state == S_WAIT) ? tcnt + TW'(1) : '0;
            if (accept) begin
                tout_q <= 1'b0;
            end else if (expire) begin
                tout_q <= 1'b1;
            end
            if (expire) begin
                to_hit <= 1'b1;
            end else if (state == S_STORE) begin
                to_hit <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        F_ST      = 1'b0;
        RD        = 1'b0;
        BUSY      = 1'b1;
        F_IN      = '0;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (ST) begin
                    state_nxt = (cnt_clamp != '0) ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH: begin
                F_ST      = 1'b1;
                F_IN      = vec_rd;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                F_IN = vec_rd;
                if (F_RD || expire) begin
                    state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                F_IN      = vec_rd;
                state_nxt = last ? S_DONE : S_LAUNCH;
            end
            S_DONE: begin
                RD        = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign vec_we    = LD_WE && (state == S_IDLE);
    assign res_we    = (state == S_STORE) && !RST;
    assign res_wdata = to_hit ? '1 : F_RES;
    assign TOUT      = TO_EN ? tout_q : 1'b0;

    root_vec_ram #(
        .W     (NARGS * WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_vec_tbl (
        .clk   (CLK),
        .we    (vec_we),
        .waddr (LD_ADDR),
        .wdata (LD_DATA),
        .raddr (idx),
        .rdata (vec_rd)
    );

    root_vec_ram #(
        .W     (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_res_tbl (
        .clk   (CLK),
        .we    (res_we),
        .waddr (idx),
        .wdata (res_wdata),
        .raddr (RES_ADDR),
        .rdata (RES)
    );

endmodule

// File: tb/tb_root_batch_runner.sv
// Bench for root_batch_runner: scenario table, reset/timeout sequences and random batches vs. a summing-function model.
module tb_root_batch_runner;

    localparam int WIDTH = 16;
    localparam int NARGS = 5;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;
    localparam int VW    = NARGS * WIDTH;
`ifdef ROOT_BATCH_TIMEOUT_EN
    localparam int TIMEOUT  = 10;
    localparam bit TO_BUILD = 1'b1;
`else
    localparam int TIMEOUT  = 100000;
    localparam bit TO_BUILD = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ST = 1'b0;
    logic [CW-1:0]    CNT = '0;
    logic             LD_WE = 1'b0;
    logic [AW-1:0]    LD_ADDR = '0;
    logic [VW-1:0]    LD_DATA = '0;
    logic             F_ST;
    logic [VW-1:0]    F_IN;
    logic             F_RD = 1'b0;
    logic [WIDTH-1:0] F_RES = '0;
    logic [AW-1:0]    RES_ADDR = '0;
    logic [WIDTH-1:0] RES;
    logic             RD;
    logic             BUSY;
    logic             TOUT;

    root_batch_runner #(
        .WIDTH(WIDTH), .NARGS(NARGS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .ST(ST), .CNT(CNT),
        .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .F_ST(F_ST), .F_IN(F_IN), .F_RD(F_RD), .F_RES(F_RES),
        .RES_ADDR(RES_ADDR), .RES(RES), .RD(RD), .BUSY(BUSY), .TOUT(TOUT)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    logic [VW-1:0]    ref_vec [DEPTH];
    logic [WIDTH-1:0] ref_res [DEPTH];

    function automatic logic [WIDTH-1:0] arg_sum(input logic [VW-1:0] v);
        logic [WIDTH-1:0] s = '0;
        for (int a = 0; a < NARGS; a++) s = s + v[a*WIDTH +: WIDTH];
        return s;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Function under drive: returns the argument sum, F_RD seen by the DUT fn_lat edges after F_ST.
    int fn_lat  = 1;
    bit fn_mute = 1'b0;
    bit fn_act  = 1'b0;
    int fn_cd   = 0;
    always @(negedge CLK) begin
        F_RD = 1'b0;
        if (RST) begin
            fn_act = 1'b0;
        end else if (F_ST) begin
            fn_act = 1'b1;
            fn_cd  = fn_lat;
            F_RES  = arg_sum(F_IN);
        end else if (fn_act) begin
            fn_cd--;
            if (fn_cd == 0) begin
                fn_act = 1'b0;
                F_RD   = !fn_mute;
            end
        end
    end

    task automatic load(input int addr, input logic [VW-1:0] data);
        @(negedge CLK);
        LD_WE   = 1'b1;
        LD_ADDR = AW'(addr);
        LD_DATA = data;
        ref_vec[addr] = data;
        @(posedge CLK);
        #1 LD_WE = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [95:0] t = {$urandom(), $urandom(), $urandom()};
        return t[VW-1:0];
    endfunction

    // Edge count: the edge that samples ST is 1, result is the edge that samples RD high.
    task automatic run_batch(input int c, input int lat, input int exp_launch, input int exp_edges,
                             input bit glitch, input bit pre_ld, input logic [VW-1:0] pre_data,
                             input string nm);
        int n, edges, launches, busy_bad, fin_bad, rd_at, gl;
        n = (c > DEPTH) ? DEPTH : c;
        fn_lat = lat;
        @(negedge CLK);
        ST  = 1'b1;
        CNT = CW'(c);
        if (pre_ld) begin
            LD_WE = 1'b1; LD_ADDR = '0; LD_DATA = pre_data;
            ref_vec[0] = pre_data;
        end
        for (int i = 0; i < n; i++) ref_res[i] = (TO_BUILD && fn_mute) ? '1 : arg_sum(ref_vec[i]);
        @(posedge CLK);
        edges = 1;
        @(negedge CLK);
        ST = 1'b0; LD_WE = 1'b0;
        launches = 0; busy_bad = 0; fin_bad = 0; rd_at = 0; gl = 0;
        for (int k = 0; k < 3000 && rd_at == 0; k++) begin
            if (gl == 1) begin ST = 1'b0; LD_WE = 1'b0; gl = 2; end
            if (F_ST) launches++;
            if (BUSY && !RD && launches > 0 && launches <= DEPTH && F_IN !== ref_vec[launches-1]) fin_bad++;
            if (!BUSY) busy_bad++;
            if (RD) rd_at = edges + 1;
            if (glitch && gl == 0 && launches == 1 && !F_ST) begin
                ST = 1'b1; CNT = CW'(1);
                LD_WE = 1'b1; LD_ADDR = AW'(1); LD_DATA = '1;
                gl = 1;
            end
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        ST = 1'b0; LD_WE = 1'b0;
        check($sformatf("%s_launches", nm), launches, exp_launch);
        check($sformatf("%s_rd_edges", nm), rd_at, exp_edges);
        check($sformatf("%s_busy_gaps", nm), busy_bad, 0);
        check($sformatf("%s_fin_bad", nm), fin_bad, 0);
        check($sformatf("%s_rd_single", nm), {RD, BUSY}, 2'b00);
        check($sformatf("%s_tout", nm), TOUT, TO_BUILD && fn_mute && n > 0);
        for (int i = 0; i < n; i++) begin
            RES_ADDR = AW'(i);
            #1 check($sformatf("%s_res%0d", nm, i), RES, ref_res[i]);
        end
    endtask

    typedef struct {
        int cnt;
        int lat;
        int exp_launch;
        int exp_edges;
        bit glitch;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{cnt: 1,  lat: 4, exp_launch: 1, exp_edges: 8,  glitch: 1'b0};
        tbl[1] = '{cnt: 0,  lat: 3, exp_launch: 0, exp_edges: 2,  glitch: 1'b0};
        tbl[2] = '{cnt: 3,  lat: 1, exp_launch: 3, exp_edges: 11, glitch: 1'b0};
        tbl[3] = '{cnt: 3,  lat: 2, exp_launch: 3, exp_edges: 14, glitch: 1'b1};
        tbl[4] = '{cnt: 12, lat: 2, exp_launch: 8, exp_edges: 34, glitch: 1'b0};
        tbl[5] = '{cnt: 8,  lat: 3, exp_launch: 8, exp_edges: 42, glitch: 1'b0};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_f_st", F_ST, 0);
        check("rst_busy", BUSY, 0);
        check("rst_rd", RD, 0);
        check("rst_tout", TOUT, 0);
        check("rst_f_in", F_IN, 0);
        RST = 1'b0;

        load(0, {16'd3, 16'd2, 16'd3, 16'd3, 16'd2});
        for (int a = 1; a < DEPTH; a++) load(a, rand_vec());

        for (int i = 0; i < 6; i++) begin
            run_batch(tbl[i].cnt, tbl[i].lat, tbl[i].exp_launch, tbl[i].exp_edges,
                      tbl[i].glitch, 1'b0, '0, $sformatf("tbl%0d", i));
            if (i == 0) begin
                RES_ADDR = '0;
                #1 check("sum_is_13", RES, 13);
            end
        end

        // Write and start in the same cycle: the batch must see the new vector.
        run_batch(1, 2, 1, 6, 1'b0, 1'b1, rand_vec(), "st_with_ld");

        // Reset while vector 1 is in WAIT.
        begin
            int seen;
            seen = 0;
            fn_lat = 5;
            @(negedge CLK);
            ST = 1'b1; CNT = CW'(3);
            ref_res[0] = arg_sum(ref_vec[0]);
            @(negedge CLK);
            ST = 1'b0;
            for (int k = 0; k < 200 && seen < 2; k++) begin
                if (F_ST) seen++;
                @(negedge CLK);
            end
            check("mid_launches", seen, 2);
            check("mid_in_wait", {F_ST, BUSY, RD}, 3'b010);
            RST = 1'b1;
            @(negedge CLK);
            check("mid_rst_f_st", F_ST, 0);
            check("mid_rst_busy", BUSY, 0);
            check("mid_rst_rd", RD, 0);
            check("mid_rst_f_in", F_IN, 0);
            check("mid_rst_tout", TOUT, 0);
            @(negedge CLK);
            RST = 1'b0;
            RES_ADDR = '0;
            #1 check("mid_res0_kept", RES, ref_res[0]);
            run_batch(1, 2, 1, 6, 1'b0, 1'b0, '0, "after_rst");
        end

`ifdef ROOT_BATCH_TIMEOUT_EN
        fn_mute = 1'b1;
        run_batch(2, 1, 2, 2 + 2 * (TIMEOUT + 2), 1'b0, 1'b0, '0, "timeout");
        repeat (3) @(negedge CLK);
        check("tout_sticky", TOUT, 1);
        fn_mute = 1'b0;
        run_batch(2, 1, 2, 8, 1'b0, 1'b0, '0, "tout_clear");
`endif

        for (int r = 0; r < 6; r++) begin
            int c, lat, n;
            for (int a = 0; a < DEPTH; a++) load(a, rand_vec());
            c   = $urandom_range(0, 10);
            lat = $urandom_range(1, 5);
            n   = (c > DEPTH) ? DEPTH : c;
            run_batch(c, lat, n, 2 + n * (lat + 2), 1'b0, 1'b0, '0, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
